// File: rtl/mult_job_sequencer.sv
// Job sequencer for the ROM -> register-file -> multiplier -> RAM datapath.
// Commands queue in a small FIFO; a host read port shares the RAM address bus.
module mult_job_sequencer #(
    parameter int ADR_W      = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [ADR_W-1:0] cmd_adr1,
    input  logic [ADR_W-1:0] cmd_adr2,
    input  logic [ADR_W-1:0] cmd_dst,
    input  logic             rd_req,
    input  logic [ADR_W-1:0] rd_adr,
    output logic             rd_gnt,
    output logic             rd_valid,
    output logic [ADR_W-1:0] rom_adr,
    output logic             rf_w,
    output logic             rf_da,
    output logic             rf_sa,
    output logic             rf_sb,
    output logic             ram_w,
    output logic [ADR_W-1:0] ram_adr,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] job_cnt
);

    // state  | meaning
    // IDLE   | waiting for a queued command; pops the head when one exists
    // LOAD_A | ROM[adr1] -> R00
    // LOAD_B | ROM[adr2] -> R01
    // MUL    | multiplier output settles
    // WRITE  | product -> RAM[dst]; sequencer owns the RAM bus
    // DONE   | done pulse, job counter advanced
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        MUL    = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CMD_W = 3 * ADR_W;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    state_t           state;
    logic [CMD_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;
    logic [CMD_W-1:0] head;
    logic [ADR_W-1:0] job_adr2;
    logic [ADR_W-1:0] job_dst;
    logic [ADR_W-1:0] ram_adr_q;

    assign cmd_ready = (count != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign head      = fifo_mem[rd_ptr];
    assign busy      = (state != IDLE) || (count != '0);
    assign rf_sa     = 1'b0;
    assign rf_sb     = 1'b1;
    assign rd_gnt    = rd_req && (state != WRITE);

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_adr1, cmd_adr2, cmd_dst};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (PTR_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            job_adr2 <= '0;
            job_dst  <= '0;
            rom_adr  <= '0;
            rf_w     <= 1'b0;
            rf_da    <= 1'b0;
            ram_w    <= 1'b0;
            done     <= 1'b0;
            job_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        rom_adr  <= head[CMD_W-1 -: ADR_W];
                        job_adr2 <= head[2*ADR_W-1 -: ADR_W];
                        job_dst  <= head[ADR_W-1:0];
                        rf_w     <= 1'b1;
                        rf_da    <= 1'b0;
                        state    <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    rom_adr <= job_adr2;
                    rf_w    <= 1'b1;
                    rf_da   <= 1'b1;
                    state   <= LOAD_B;
                end
                LOAD_B: begin
                    rf_w  <= 1'b0;
                    rf_da <= 1'b0;
                    state <= MUL;
                end
                MUL: begin
                    ram_w <= 1'b1;
                    state <= WRITE;
                end
                WRITE: begin
                    ram_w   <= 1'b0;
                    done    <= 1'b1;
                    job_cnt <= job_cnt + CNT_W'(1);
                    state   <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    rf_w  <= 1'b0;
                    rf_da <= 1'b0;
                    ram_w <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // With no owner the bus keeps its previous address, so the RAM just refreshes data_out.
    always_comb begin
        ram_adr = ram_adr_q;
        if (state == WRITE) begin
            ram_adr = job_dst;
        end else if (rd_gnt) begin
            ram_adr = rd_adr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_adr_q <= '0;
            rd_valid  <= 1'b0;
        end else begin
            ram_adr_q <= ram_adr;
            rd_valid  <= rd_gnt;
        end
    end

endmodule
